// File: rtl/ga_run_sched_pkg.sv
// ---------------------------------------------------------------------------
// ga_pkg
// Shared types for the GA engine run scheduler.
//   run_sched_fsm_st_type : scheduler phase (IDLE/INIT/GEN/DONE)
//   ga_result_type        : run outcome as reported to SW
// ---------------------------------------------------------------------------
package ga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_GEN  = 2'd2,
    ST_DONE = 2'd3
  } run_sched_fsm_st_type;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_FOUND   = 2'b01,
    RES_MAX_GEN = 2'b10,
    RES_TIMEOUT = 2'b11
  } ga_result_type;

endpackage

// File: rtl/ga_wdog_cnt.sv
// ---------------------------------------------------------------------------
// ga_wdog_cnt
// Saturating idle-cycle counter for the run scheduler.
// Ports:
//   clk, rstn : clock, async active-low reset
//   en        : count this cycle (scheduler is in INIT or GEN)
//   clr       : progress / phase entry / soft reset, restarts the count
//   expired   : this cycle's increment brings the count to all-ones
// ---------------------------------------------------------------------------
module ga_wdog_cnt #(
  parameter int WDOG_W = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [WDOG_W-1:0] C_MAX = '1;
  localparam logic [WDOG_W-1:0] C_PRE = C_MAX - WDOG_W'(1);

  logic [WDOG_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      r_cnt <= '0;
    else if (clr)                   r_cnt <= '0;
    else if (en && r_cnt != C_MAX)  r_cnt <= r_cnt + WDOG_W'(1);
  end

  // Flag on the increment that reaches all-ones, so the scheduler leaves in
  // that same cycle. A clear (progress) in that cycle suppresses it.
  assign expired = en & ~clr & (r_cnt == C_PRE);

endmodule

// File: rtl/ga_run_sched.sv
// ---------------------------------------------------------------------------
// ga_run_sched
// Top-level run scheduler for the GA engine: starts the initial-population
// generator, counts its pushes up to P, then issues one start per generation
// until fitness is found, max generations are done, or the watchdog expires.
// Ports:
//   clk, rstn       : clock, async active-low reset
//   sw_rst          : sync soft reset, beats every other event
//   cnfg_p          : population size P (latched at start)
//   cnfg_max_gen    : max generations (latched at start)
//   sw_start_pls    : run request, honoured only when idle
//   init_push       : init-pop queue push (monitored)
//   gen_done_pls    : generation finished
//   fit_found_pls   : target fitness reached
//   init_start_pls  : start to init-pop generator
//   gen_start_pls   : start to generation engine
//   done_pls        : run complete
//   cfg_err_pls     : start rejected, P==0 or max_gen==0
//   busy            : run in progress (state != IDLE)
//   gen_count       : generations completed in current/last run
//   result          : outcome, see ga_result_type
// Interface: every *_pls/push signal is a single-cycle strobe sampled at the
// rising edge; there is no back-pressure. Outputs are all registered, so a
// strobe seen at edge N produces its response pulse during cycle N+1.
// ---------------------------------------------------------------------------
module ga_run_sched
  import ga_pkg::*;
#(
  parameter int P_MAX_W = 8,
  parameter int GEN_W   = 16,
  parameter int WDOG_W  = 20
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sw_rst,
  input  logic [P_MAX_W-1:0] cnfg_p,
  input  logic [GEN_W-1:0]   cnfg_max_gen,
  input  logic               sw_start_pls,
  input  logic               init_push,
  input  logic               gen_done_pls,
  input  logic               fit_found_pls,
  output logic               init_start_pls,
  output logic               gen_start_pls,
  output logic               done_pls,
  output logic               cfg_err_pls,
  output logic               busy,
  output logic [GEN_W-1:0]   gen_count,
  output logic [1:0]         result
);

  run_sched_fsm_st_type r_state,     w_state_nx;
  ga_result_type        r_result,    w_result_nx;
  logic [P_MAX_W-1:0]   r_p_lat,     w_p_lat_nx;
  logic [GEN_W-1:0]     r_mg_lat,    w_mg_lat_nx;
  logic [P_MAX_W-1:0]   r_push_cnt,  w_push_cnt_nx;
  logic [GEN_W-1:0]     r_gen_count, w_gen_count_nx;
  logic r_init_start, w_init_start_nx;
  logic r_gen_start,  w_gen_start_nx;
  logic r_done,       w_done_nx;
  logic r_cfg_err,    w_cfg_err_nx;
  logic r_busy,       w_busy_nx;

  logic [P_MAX_W-1:0] w_push_inc;
  logic [GEN_W-1:0]   w_gen_inc;
  logic w_wdog_en, w_wdog_clr, w_wdog_exp;

  assign w_push_inc = r_push_cnt + P_MAX_W'(1);
  // gen_count never wraps
  assign w_gen_inc  = (r_gen_count == '1) ? r_gen_count : r_gen_count + GEN_W'(1);

  // Held clear while idle, so every INIT entry starts from zero; the INIT->GEN
  // entry coincides with the final counted push, which clears it anyway.
  assign w_wdog_en  = (r_state == ST_INIT) || (r_state == ST_GEN);
  assign w_wdog_clr = sw_rst || (r_state == ST_IDLE)
                   || ((r_state == ST_INIT) && init_push)
                   || ((r_state == ST_GEN)  && gen_done_pls);

  ga_wdog_cnt #(.WDOG_W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .en      (w_wdog_en),
    .clr     (w_wdog_clr),
    .expired (w_wdog_exp)
  );

  always_comb begin
    w_state_nx      = r_state;
    w_result_nx     = r_result;
    w_p_lat_nx      = r_p_lat;
    w_mg_lat_nx     = r_mg_lat;
    w_push_cnt_nx   = r_push_cnt;
    w_gen_count_nx  = r_gen_count;
    w_init_start_nx = 1'b0;
    w_gen_start_nx  = 1'b0;
    w_done_nx       = 1'b0;
    w_cfg_err_nx    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sw_start_pls) begin
          if (cnfg_p != '0 && cnfg_max_gen != '0) begin
            w_state_nx      = ST_INIT;
            w_p_lat_nx      = cnfg_p;
            w_mg_lat_nx     = cnfg_max_gen;
            w_push_cnt_nx   = '0;
            w_gen_count_nx  = '0;
            w_result_nx     = RES_NONE;
            w_init_start_nx = 1'b1;
          end else begin
            w_cfg_err_nx = 1'b1;
          end
        end
      end
      ST_INIT: begin
        if (init_push) begin
          w_push_cnt_nx = w_push_inc;
          if (w_push_inc == r_p_lat) begin
            w_state_nx     = ST_GEN;
            w_gen_start_nx = 1'b1;
          end
        end else if (w_wdog_exp) begin
          w_state_nx  = ST_DONE;
          w_result_nx = RES_TIMEOUT;
          w_done_nx   = 1'b1;
        end
      end
      ST_GEN: begin
        if (gen_done_pls) w_gen_count_nx = w_gen_inc;
        // FOUND outranks a simultaneous gen_done, which still gets counted
        if (fit_found_pls) begin
          w_state_nx  = ST_DONE;
          w_result_nx = RES_FOUND;
          w_done_nx   = 1'b1;
        end else if (gen_done_pls) begin
          if (w_gen_inc == r_mg_lat) begin
            w_state_nx  = ST_DONE;
            w_result_nx = RES_MAX_GEN;
            w_done_nx   = 1'b1;
          end else begin
            w_gen_start_nx = 1'b1;
          end
        end else if (w_wdog_exp) begin
          w_state_nx  = ST_DONE;
          w_result_nx = RES_TIMEOUT;
          w_done_nx   = 1'b1;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= ST_IDLE; else if (sw_rst) r_state <= ST_IDLE; else r_state <= w_state_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_result <= RES_NONE; else if (sw_rst) r_result <= RES_NONE; else r_result <= w_result_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_p_lat <= '0; else if (sw_rst) r_p_lat <= '0; else r_p_lat <= w_p_lat_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_mg_lat <= '0; else if (sw_rst) r_mg_lat <= '0; else r_mg_lat <= w_mg_lat_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_push_cnt <= '0; else if (sw_rst) r_push_cnt <= '0; else r_push_cnt <= w_push_cnt_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_gen_count <= '0; else if (sw_rst) r_gen_count <= '0; else r_gen_count <= w_gen_count_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_init_start <= 1'b0; else if (sw_rst) r_init_start <= 1'b0; else r_init_start <= w_init_start_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_gen_start <= 1'b0; else if (sw_rst) r_gen_start <= 1'b0; else r_gen_start <= w_gen_start_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_done <= 1'b0; else if (sw_rst) r_done <= 1'b0; else r_done <= w_done_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_cfg_err <= 1'b0; else if (sw_rst) r_cfg_err <= 1'b0; else r_cfg_err <= w_cfg_err_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_busy <= 1'b0; else if (sw_rst) r_busy <= 1'b0; else r_busy <= w_busy_nx;

  assign init_start_pls = r_init_start;
  assign gen_start_pls  = r_gen_start;
  assign done_pls       = r_done;
  assign cfg_err_pls    = r_cfg_err;
  assign busy           = r_busy;
  assign gen_count      = r_gen_count;
  assign result         = r_result;

endmodule

// File: tb/tb_ga_run_sched.sv
// ---------------------------------------------------------------------------
// tb_ga_run_sched
// Directed and randomized runs of ga_run_sched (watchdog width 4, limit 15).
// A run-level reference model predicts every cycle's outputs into exp_q;
// a negedge monitor pops and compares. Directed scenarios add end-of-run
// checks against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_ga_run_sched;

  localparam int P_MAX_W    = 8;
  localparam int GEN_W      = 16;
  localparam int WDOG_W     = 4;
  localparam int WDOG_LIMIT = (1 << WDOG_W) - 1;
  localparam int GEN_SAT    = (1 << GEN_W) - 1;
  localparam int OBS_W      = 5 + GEN_W + 2;

  localparam int PH_IDLE = 0, PH_FILL = 1, PH_EVOLVE = 2, PH_FINISH = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rstn, sw_rst;
  logic [P_MAX_W-1:0] cnfg_p;
  logic [GEN_W-1:0]   cnfg_max_gen;
  logic sw_start_pls, init_push, gen_done_pls, fit_found_pls;
  logic init_start_pls, gen_start_pls, done_pls, cfg_err_pls, busy;
  logic [GEN_W-1:0] gen_count;
  logic [1:0]       result;

  always #5 clk = ~clk;

  ga_run_sched #(.P_MAX_W(P_MAX_W), .GEN_W(GEN_W), .WDOG_W(WDOG_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sw_rst         (sw_rst),
    .cnfg_p         (cnfg_p),
    .cnfg_max_gen   (cnfg_max_gen),
    .sw_start_pls   (sw_start_pls),
    .init_push      (init_push),
    .gen_done_pls   (gen_done_pls),
    .fit_found_pls  (fit_found_pls),
    .init_start_pls (init_start_pls),
    .gen_start_pls  (gen_start_pls),
    .done_pls       (done_pls),
    .cfg_err_pls    (cfg_err_pls),
    .busy           (busy),
    .gen_count      (gen_count),
    .result         (result)
  );

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int obs_init = 0, obs_gen = 0, obs_done = 0, obs_err = 0;

  // ---------------- reference model ----------------
  int m_phase, m_p, m_mg, m_pushes, m_gens, m_quiet, m_result;
  bit m_init_p, m_gen_p, m_done_p, m_err_p;

  task automatic model_reset();
    m_phase = PH_IDLE; m_p = 0; m_mg = 0; m_pushes = 0; m_gens = 0;
    m_quiet = 0; m_result = 0;
    m_init_p = 0; m_gen_p = 0; m_done_p = 0; m_err_p = 0;
  endtask

  task automatic finish_run(input int outcome);
    m_phase  = PH_FINISH;
    m_result = outcome;
    m_done_p = 1;
  endtask

  // One clock edge worth of run rules, given the inputs about to be sampled.
  task automatic model_step();
    if (!rstn || sw_rst) begin
      model_reset();
      return;
    end
    m_init_p = 0; m_gen_p = 0; m_done_p = 0; m_err_p = 0;
    case (m_phase)
      PH_IDLE: if (sw_start_pls) begin
        if (cnfg_p != 0 && cnfg_max_gen != 0) begin
          m_p = int'(cnfg_p); m_mg = int'(cnfg_max_gen);
          m_pushes = 0; m_gens = 0; m_quiet = 0; m_result = 0;
          m_phase = PH_FILL; m_init_p = 1;
        end else begin
          m_err_p = 1;
        end
      end
      PH_FILL: begin
        if (init_push) begin
          m_pushes++; m_quiet = 0;
          if (m_pushes == m_p) begin m_phase = PH_EVOLVE; m_gen_p = 1; end
        end else begin
          m_quiet++;
          if (m_quiet == WDOG_LIMIT) finish_run(3);
        end
      end
      PH_EVOLVE: begin
        if (gen_done_pls) begin
          if (m_gens < GEN_SAT) m_gens++;
          m_quiet = 0;
        end else begin
          m_quiet++;
        end
        if (fit_found_pls)              finish_run(1);
        else if (gen_done_pls) begin
          if (m_gens == m_mg) finish_run(2);
          else                m_gen_p = 1;
        end else if (m_quiet == WDOG_LIMIT) finish_run(3);
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  function automatic logic [OBS_W-1:0] model_vec();
    return {(m_phase != PH_IDLE), m_init_p, m_gen_p, m_done_p, m_err_p,
            GEN_W'(m_gens), 2'(m_result)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [OBS_W-1:0] act_v, exp_v;
    if (init_start_pls) obs_init++;
    if (gen_start_pls)  obs_gen++;
    if (done_pls)       obs_done++;
    if (cfg_err_pls)    obs_err++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {busy, init_start_pls, gen_start_pls, done_pls, cfg_err_pls, gen_count, result};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cyc %0d: actual busy/init/gen/done/err=%b gen_count=%0d result=%b, required busy/init/gen/done/err=%b gen_count=%0d result=%b",
                 cyc, act_v[OBS_W-1 -: 5], act_v[GEN_W+1:2], act_v[1:0],
                 exp_v[OBS_W-1 -: 5], exp_v[GEN_W+1:2], exp_v[1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    model_step();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    sw_start_pls = 0; init_push = 0; gen_done_pls = 0; fit_found_pls = 0; sw_rst = 0;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_run(input int p, input int mg);
    cnfg_p = P_MAX_W'(p); cnfg_max_gen = GEN_W'(mg); sw_start_pls = 1; tick();
  endtask

  task automatic push_n(input int n);
    repeat (n) begin init_push = 1; tick(); idle(1); end
  endtask

  task automatic gen_done_once();
    gen_done_pls = 1; tick(); idle(2);
  endtask

  task automatic clear_obs();
    obs_init = 0; obs_gen = 0; obs_done = 0; obs_err = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int thr, wait_n;
    bit slow;
    rstn = 0; sw_rst = 0; cnfg_p = 0; cnfg_max_gen = 0;
    sw_start_pls = 0; init_push = 0; gen_done_pls = 0; fit_found_pls = 0;
    model_reset();
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_result", int'(result), 0);
    idle(3);
    rstn = 1;
    idle(2);

    // P=4, max_gen=3, no fitness: MAX_GEN after three generations
    clear_obs();
    start_run(4, 3);
    chk("t1_init_start_latency", int'(init_start_pls), 1);
    push_n(4);
    repeat (3) gen_done_once();
    idle(3);
    chk("t1_gen_starts", obs_gen, 3);
    chk("t1_done_pulses", obs_done, 1);
    chk("t1_result", int'(result), 2);
    chk("t1_gen_count", int'(gen_count), 3);

    // P=2, max_gen=10, fitness together with the 2nd gen_done
    clear_obs();
    start_run(2, 10);
    push_n(2);
    gen_done_once();
    fit_found_pls = 1; gen_done_pls = 1; tick();
    idle(5);
    chk("t2_result", int'(result), 1);
    chk("t2_gen_count", int'(gen_count), 2);
    chk("t2_gen_starts", obs_gen, 2);
    chk("t2_done_pulses", obs_done, 1);

    // invalid configurations are rejected
    clear_obs();
    start_run(0, 5);
    chk("t3_busy_after_bad_p", int'(busy), 0);
    idle(2);
    start_run(3, 0);
    idle(2);
    chk("t3_err_pulses", obs_err, 2);
    chk("t3_init_starts", obs_init, 0);

    // watchdog: P=3 but only two pushes arrive
    clear_obs();
    start_run(3, 4);
    push_n(1);
    init_push = 1; tick();
    wait_n = 0;
    while (!done_pls && wait_n < 40) begin tick(); wait_n++; end
    chk("t4_timeout_latency", wait_n, WDOG_LIMIT);
    idle(3);
    chk("t4_result", int'(result), 3);
    chk("t4_done_pulses", obs_done, 1);

    // soft reset mid-GEN, then a clean run
    clear_obs();
    start_run(1, 5);
    push_n(1);
    gen_done_once();
    sw_rst = 1; gen_done_pls = 1; tick();
    chk("t5_busy", int'(busy), 0);
    chk("t5_gen_count", int'(gen_count), 0);
    chk("t5_result", int'(result), 0);
    idle(2);
    chk("t5_done_pulses", obs_done, 0);
    start_run(1, 1);
    push_n(1);
    gen_done_once();
    idle(2);
    chk("t5_rerun_result", int'(result), 2);

    // restart requests and cnfg changes mid-run are ignored
    clear_obs();
    start_run(3, 2);
    push_n(1);
    cnfg_p = 1; cnfg_max_gen = 1; sw_start_pls = 1; tick();
    push_n(1);
    chk("t6_still_filling", obs_gen, 0);
    sw_start_pls = 1; tick();
    push_n(1);
    gen_done_once();
    gen_done_once();
    idle(3);
    chk("t6_init_starts", obs_init, 1);
    chk("t6_err_pulses", obs_err, 0);
    chk("t6_result", int'(result), 2);
    chk("t6_gen_count", int'(gen_count), 2);

    // randomized runs, some deliberately slow enough to time out
    for (int r = 0; r < 60; r++) begin
      slow = ($urandom_range(0, 3) == 0);
      thr  = slow ? 24 : 3;
      cnfg_p       = ($urandom_range(0, 9) == 0) ? '0 : P_MAX_W'($urandom_range(1, 5));
      cnfg_max_gen = ($urandom_range(0, 9) == 0) ? '0 : GEN_W'($urandom_range(1, 4));
      sw_start_pls = 1;
      tick();
      for (int c = 0; c < 200 && m_phase != PH_IDLE; c++) begin
        init_push     = ($urandom_range(0, thr - 1) == 0);
        gen_done_pls  = ($urandom_range(0, thr) == 0);
        fit_found_pls = ($urandom_range(0, 29) == 0);
        sw_start_pls  = ($urandom_range(0, 19) == 0);
        sw_rst        = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 9) == 0) cnfg_p = P_MAX_W'($urandom_range(0, 5));
        tick();
      end
      idle(2);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
